// File: rtl/bin_avg_pkg.sv
// Shared types and width helpers for the bin averaging readout.
package bin_avg_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } bin_avg_state_t;

    // Width of a bin index; never below one bit.
    function automatic int unsigned bin_idx_w(input int unsigned n_bins);
        return (n_bins < 2) ? 1 : $clog2(n_bins);
    endfunction

    localparam int unsigned DEFAULT_BIN_W = bin_idx_w(4);

endpackage

// File: rtl/bin_avg_scaler.sv
// Divide one accumulated sum by 2^LOG2_FRAMES and saturate to OUT_WIDTH.
// BIN_AVG_ROUND_EN selects round half-up instead of truncation.
module bin_avg_scaler #(
    parameter int unsigned SUM_WIDTH   = 128,
    parameter int unsigned OUT_WIDTH   = 32,
    parameter int unsigned LOG2_FRAMES = 4
) (
    input  logic [SUM_WIDTH-1:0] in_sum,
    output logic [OUT_WIDTH-1:0] out_avg_c
);

    localparam int unsigned XW = SUM_WIDTH + 1;

    logic [XW-1:0] w_ext;
    logic [XW-1:0] w_rnd;
    logic [XW-1:0] w_shf;

    assign w_ext = {1'b0, in_sum};

`ifdef BIN_AVG_ROUND_EN
    // Extra headroom bit means adding the half-LSB can never wrap.
    assign w_rnd = w_ext + (XW'(1) << (LOG2_FRAMES - 1));
`else
    assign w_rnd = w_ext;
`endif

    assign w_shf = w_rnd >> LOG2_FRAMES;

    generate
        if (XW > OUT_WIDTH) begin : g_sat
            logic w_ovf;
            assign w_ovf     = |w_shf[XW-1:OUT_WIDTH];
            assign out_avg_c = w_ovf ? {OUT_WIDTH{1'b1}} : w_shf[OUT_WIDTH-1:0];
        end else begin : g_nosat
            assign out_avg_c = OUT_WIDTH'(w_shf);
        end
    endgenerate

endmodule

// File: rtl/bin_average_readout.sv
// Frame counter, snapshot and valid/ready burst of per-bin averages.
// Rounding mode is chosen by BIN_AVG_ROUND_EN (see bin_avg_scaler).
module bin_average_readout
    import bin_avg_pkg::*;
#(
    parameter int unsigned BINS        = 4,
    parameter int unsigned SUM_WIDTH   = 128,
    parameter int unsigned OUT_WIDTH   = 32,
    parameter int unsigned LOG2_FRAMES = 4,
    localparam int unsigned BIN_W      = bin_idx_w(BINS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BINS-1:0][SUM_WIDTH-1:0] in_sums,
    input  logic                           in_frame_done,
    output logic                           sum_clear,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic [BIN_W-1:0]               out_bin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           overrun
);

    bin_avg_state_t         r_state;
    logic [LOG2_FRAMES-1:0] r_frame_cnt;
    logic [SUM_WIDTH-1:0]   r_snap [BINS];

    logic                 w_accept;
    logic                 w_final;
    logic                 w_trigger;
    logic                 w_capture;
    logic [BIN_W-1:0]     w_next_bin;
    logic [SUM_WIDTH-1:0] w_scale_in;
    logic [OUT_WIDTH-1:0] w_scaled;

    assign w_accept   = out_valid && out_ready;
    assign w_final    = w_accept && out_last;
    assign w_trigger  = in_frame_done && (r_frame_cnt == {LOG2_FRAMES{1'b1}});
    assign w_capture  = w_trigger && ((r_state == IDLE) || w_final);
    assign w_next_bin = out_bin + BIN_W'(1);

    // On capture the first beat comes straight from the incoming sums so it can
    // be registered on the same edge as the snapshot.
    always_comb begin
        w_scale_in = r_snap[w_next_bin];
        if (w_capture) begin
            w_scale_in = in_sums[0];
        end
    end

    bin_avg_scaler #(
        .SUM_WIDTH   (SUM_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .LOG2_FRAMES (LOG2_FRAMES)
    ) u_scaler (
        .in_sum    (w_scale_in),
        .out_avg_c (w_scaled)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            sum_clear   <= 1'b0;
            overrun     <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_bin     <= '0;
            out_data    <= '0;
            for (int b = 0; b < int'(BINS); b++) begin
                r_snap[b] <= '0;
            end
        end else begin
            sum_clear <= w_trigger;
            if (in_frame_done) begin
                r_frame_cnt <= r_frame_cnt + LOG2_FRAMES'(1);
            end
            if (w_trigger && !w_capture) begin
                overrun <= 1'b1;
            end

            if (w_capture) begin
                for (int b = 0; b < int'(BINS); b++) begin
                    r_snap[b] <= in_sums[b];
                end
                r_state   <= STREAM;
                out_valid <= 1'b1;
                out_bin   <= '0;
                out_last  <= 1'b0;
                out_data  <= w_scaled;
            end else if (w_accept) begin
                if (out_last) begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_bin  <= w_next_bin;
                    out_last <= (w_next_bin == BIN_W'(BINS - 1));
                    out_data <= w_scaled;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_average_readout.sv
// Directed bench for bin_average_readout with BINS=4, LOG2_FRAMES=4, OUT_WIDTH=32.
module tb_bin_average_readout;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [3:0][127:0]     in_sums;
    logic                  in_frame_done;
    logic                  sum_clear;
    logic [31:0]           out_data;
    logic [1:0]            out_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  overrun;

    int n_total = 0;
    int n_bad   = 0;
    int n_clr   = 0;

    logic [31:0] q_data [$];
    int          q_bin  [$];
    logic        q_last [$];

`ifdef BIN_AVG_ROUND_EN
    localparam logic [31:0] A0 = 32'd63;
    localparam logic [31:0] A3 = 32'd1;
`else
    localparam logic [31:0] A0 = 32'd62;
    localparam logic [31:0] A3 = 32'd0;
`endif
    localparam logic [31:0] A1 = 32'd100;
    localparam logic [31:0] A2 = 32'd2;

    bin_average_readout #(
        .BINS        (4),
        .SUM_WIDTH   (128),
        .OUT_WIDTH   (32),
        .LOG2_FRAMES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_sums       (in_sums),
        .in_frame_done (in_frame_done),
        .sum_clear     (sum_clear),
        .out_data      (out_data),
        .out_bin       (out_bin),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Record accepted beats and clear pulses midway between edges.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_bin.push_back(int'(out_bin));
            q_last.push_back(out_last);
        end
        if (sum_clear) n_clr++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_data.delete();
        q_bin.delete();
        q_last.delete();
        n_clr = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_sums(input logic [127:0] s0, input logic [127:0] s1,
                            input logic [127:0] s2, input logic [127:0] s3);
        in_sums[0] = s0;
        in_sums[1] = s1;
        in_sums[2] = s2;
        in_sums[3] = s3;
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            in_frame_done = 1'b1;
            tick();
            in_frame_done = 1'b0;
            tick();
        end
    endtask

    // Final frame of a group; returns just after the sampling edge.
    task automatic trigger();
        in_frame_done = 1'b1;
        tick();
        in_frame_done = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 40 && q_data.size() < n; i++) tick();
        tick();
        tick();
        chk({tag, "_count"}, 64'(q_data.size()), 64'(n));
    endtask

    task automatic check_burst(input string tag, input int base,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp_d [4];
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
        for (int b = 0; b < 4; b++) begin
            if (base + b < q_data.size()) begin
                chk($sformatf("%s_bin%0d", tag, b),  64'(q_bin[base+b]),  64'(b));
                chk($sformatf("%s_data%0d", tag, b), 64'(q_data[base+b]), 64'(exp_d[b]));
                chk($sformatf("%s_last%0d", tag, b), 64'(q_last[base+b]), 64'(b == 3));
            end else begin
                chk($sformatf("%s_missing%0d", tag, b), 64'(q_data.size()), 64'(base + b + 1));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_frame_done = 1'b0;
        out_ready = 1'b1;
        set_sums(128'd0, 128'd0, 128'd0, 128'd0);
        do_reset();

        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last",  64'(out_last),  64'd0);
        chk("rst_clear", 64'(sum_clear), 64'd0);
        chk("rst_ovr",   64'(overrun),   64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_bin",   64'(out_bin),   64'd0);

        // Basic average
        clear_log();
        set_sums(128'd1000, 128'd1600, 128'd32, 128'd15);
        pulse_frames(15);
        chk("basic_early", 64'(out_valid), 64'd0);
        trigger();
        chk("basic_clr_hi", 64'(sum_clear), 64'd1);
        chk("basic_first_valid", 64'(out_valid), 64'd1);
        chk("basic_first_data", 64'(out_data), 64'(A0));
        tick();
        chk("basic_clr_lo", 64'(sum_clear), 64'd0);
        wait_beats("basic", 4);
        check_burst("basic", 0, A0, A1, A2, A3);
        chk("basic_nclr", 64'(n_clr), 64'd1);
        chk("basic_idle", 64'(out_valid), 64'd0);

        // Backpressure on bin 1
        clear_log();
        pulse_frames(15);
        trigger();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_bin",   64'(out_bin),   64'd1);
            chk("bp_data",  64'(out_data),  64'd100);
            tick();
        end
        out_ready = 1'b1;
        wait_beats("bp", 4);
        check_burst("bp", 0, A0, A1, A2, A3);

        // Saturation on bin 2
        clear_log();
        set_sums(128'd1000, 128'd1600, 128'd1 << 40, 128'd15);
        pulse_frames(15);
        trigger();
        wait_beats("sat", 4);
        check_burst("sat", 0, A0, A1, 32'hFFFF_FFFF, A3);

        // Trigger coincides with acceptance of the final beat
        clear_log();
        set_sums(128'd1000, 128'd1600, 128'd32, 128'd15);
        out_ready = 1'b0;
        pulse_frames(15);
        trigger();
        pulse_frames(15);
        set_sums(128'd320, 128'd48, 128'd4000, 128'd1);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("b2b_last_shown", 64'(out_last), 64'd1);
        trigger();
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_bin",   64'(out_bin),   64'd0);
        chk("b2b_data",  64'(out_data),  64'd20);
        chk("b2b_ovr",   64'(overrun),   64'd0);
        wait_beats("b2b", 8);
        check_burst("b2b_a", 0, A0, A1, A2, A3);
        check_burst("b2b_b", 4, 32'd20, 32'd3, 32'd250, 32'd0);
        chk("b2b_nclr", 64'(n_clr), 64'd2);

        // Overrun while a stalled burst is pending
        clear_log();
        set_sums(128'd1000, 128'd1600, 128'd32, 128'd15);
        out_ready = 1'b0;
        pulse_frames(15);
        trigger();
        set_sums(128'd320, 128'd48, 128'd4000, 128'd1);
        pulse_frames(15);
        chk("ovr_before", 64'(overrun), 64'd0);
        trigger();
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_clr", 64'(sum_clear), 64'd1);
        chk("ovr_hold_data", 64'(out_data), 64'(A0));
        out_ready = 1'b1;
        wait_beats("ovr", 4);
        check_burst("ovr", 0, A0, A1, A2, A3);
        chk("ovr_nclr", 64'(n_clr), 64'd2);
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Reset in the middle of a burst
        do_reset();
        clear_log();
        set_sums(128'd1000, 128'd1600, 128'd32, 128'd15);
        pulse_frames(15);
        trigger();
        tick();
        tick();
        reset = 1'b1;
        in_frame_done = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_bin",   64'(out_bin),   64'd0);
        chk("mid_rst_data",  64'(out_data),  64'd0);
        chk("mid_rst_last",  64'(out_last),  64'd0);
        chk("mid_rst_clr",   64'(sum_clear), 64'd0);
        chk("mid_rst_ovr",   64'(overrun),   64'd0);
        reset = 1'b0;
        in_frame_done = 1'b0;
        tick();
        clear_log();
        set_sums(128'd320, 128'd48, 128'd4000, 128'd1);
        pulse_frames(15);
        chk("mid_rst_cnt_nclr", 64'(n_clr), 64'd0);
        chk("mid_rst_cnt_idle", 64'(out_valid), 64'd0);
        trigger();
        chk("mid_rst_new_valid", 64'(out_valid), 64'd1);
        wait_beats("mid_rst", 4);
        check_burst("mid_rst", 0, 32'd20, 32'd3, 32'd250, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
